// File: rtl/clk_tick_pkg.sv
// Shared constants and helpers for the cascaded clock-enable divider chain.
package clk_tick_pkg;

  localparam int DEFAULT_DIV = 4;
  localparam int STAGES_MIN  = 1;
  localparam int STAGES_MAX  = 16;

  function automatic int sel_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

  // Divisors 0 and 1 both mean pass-through.
  function automatic logic [31:0] eff_div(input logic [31:0] active);
    return (active < 32'd2) ? 32'd1 : active;
  endfunction

endpackage

// File: rtl/clk_tick_stage.sv
// One divide-by-N stage: counter, shadowed divisor, carry out, tick and level.
module clk_tick_stage
  import clk_tick_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = clk_tick_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             wrap,
  output logic             tick,
  output logic             level,
  output logic             pending
);

  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] pending_div;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] term;

  assign d    = DIV_W'(eff_div(32'(active)));
  assign term = d - DIV_W'(1);
  assign wrap = step && (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      active      <= DEF;
      pending_div <= DEF;
      pending     <= 1'b0;
      tick        <= 1'b0;
      level       <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      active  <= pending_div;
      pending <= 1'b0;
      tick    <= 1'b0;
      level   <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) level <= ~level;
      if (step) cnt <= wrap ? '0 : cnt + DIV_W'(1);
      // Swap only at a wrap so a count in progress is never cut short.
      if (wrap && pending) begin
        active  <= pending_div;
        pending <= 1'b0;
      end
      // A write landing on the wrap cycle re-arms for the following wrap.
      if (wr) begin
        pending_div <= wr_data;
        pending     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_tick_chain.sv
// Prescaler feeding STAGES cascaded divide-by-N clock-enable stages.
module clk_tick_chain
  import clk_tick_pkg::*;
#(
  parameter int STAGES      = 7,
  parameter int DIV_W       = 8,
  parameter int PRESCALE_W  = 19,
  parameter int DEFAULT_DIV = clk_tick_pkg::DEFAULT_DIV,
  localparam int SEL_W      = sel_w(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale_div,
  input  logic                  div_wr,
  input  logic [SEL_W-1:0]      div_sel,
  input  logic [DIV_W-1:0]      div_data,
  output logic [STAGES-1:0]     tick,
  output logic [STAGES-1:0]     level,
  output logic [STAGES-1:0]     pending
);

  logic [PRESCALE_W-1:0] pcnt;
  logic [PRESCALE_W-1:0] plim;
  logic                  pterm;
  logic [STAGES-1:0]     wrap;

  // >= rather than == so a live shrink of prescale_div cannot overrun.
  assign plim  = (prescale_div == '0) ? '0 : prescale_div - PRESCALE_W'(1);
  assign pterm = en && (pcnt >= plim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pcnt <= '0;
    else if (clear) pcnt <= '0;
    else if (pterm) pcnt <= '0;
    else if (en)    pcnt <= pcnt + PRESCALE_W'(1);
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic step;
    logic wr;

    if (i == 0) begin : g_first
      assign step = pterm;
    end else begin : g_next
      assign step = wrap[i-1];
    end

    assign wr = div_wr && !clear && (div_sel == SEL_W'(i));

    clk_tick_stage #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .step    (step),
      .wr      (wr),
      .wr_data (div_data),
      .wrap    (wrap[i]),
      .tick    (tick[i]),
      .level   (level[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_tick_chain.sv
// Scoreboard bench for clk_tick_chain against a behavioural chain model.
module tb_clk_tick_chain;

  localparam int STAGES = 7;
  localparam int DIV_W  = 8;
  localparam int PW     = 19;
  localparam int SW     = 3;
  localparam int DEF    = 4;

  typedef logic [3*STAGES-1:0] exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clear;
  logic [PW-1:0]     prescale_div;
  logic              div_wr;
  logic [SW-1:0]     div_sel;
  logic [DIV_W-1:0]  div_data;
  logic [STAGES-1:0] tick;
  logic [STAGES-1:0] level;
  logic [STAGES-1:0] pending;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  // Model state: prescaler position, per-stage position within its divide ratio.
  int m_pc;
  int m_cnt [STAGES];
  int m_act [STAGES];
  int m_pdv [STAGES];
  bit m_pend[STAGES];
  bit m_lvl [STAGES];
  bit m_tick[STAGES];

  always #5 clk = ~clk;

  clk_tick_chain #(
    .STAGES      (STAGES),
    .DIV_W       (DIV_W),
    .PRESCALE_W  (PW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clear        (clear),
    .prescale_div (prescale_div),
    .div_wr       (div_wr),
    .div_sel      (div_sel),
    .div_data     (div_data),
    .tick         (tick),
    .level        (level),
    .pending      (pending)
  );

  function automatic exp_t pack_exp();
    exp_t e;
    e = '0;
    for (int i = 0; i < STAGES; i++) begin
      e[i]            = m_tick[i];
      e[STAGES+i]     = m_lvl[i];
      e[2*STAGES+i]   = m_pend[i];
    end
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < STAGES; i++) begin
      m_cnt[i] = 0; m_act[i] = DEF; m_pdv[i] = DEF;
      m_pend[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
    end
  endtask

  task automatic model_step();
    int  p, d;
    bit  carry, c;
    if (clear) begin
      m_pc = 0;
      for (int i = 0; i < STAGES; i++) begin
        m_cnt[i] = 0; m_tick[i] = 0; m_lvl[i] = 0;
        m_act[i] = m_pdv[i]; m_pend[i] = 0;
      end
      return;
    end
    p = (prescale_div == 0) ? 1 : int'(prescale_div);
    carry = en && (m_pc >= p - 1);
    if (carry) m_pc = 0;
    else if (en) m_pc++;
    for (int i = 0; i < STAGES; i++) begin
      d = (m_act[i] < 2) ? 1 : m_act[i];
      c = carry && (m_cnt[i] == d - 1);
      m_tick[i] = c;
      if (c) m_lvl[i] = !m_lvl[i];
      if (carry) m_cnt[i] = c ? 0 : m_cnt[i] + 1;
      if (c && m_pend[i]) begin
        m_act[i] = m_pdv[i];
        m_pend[i] = 0;
      end
      carry = c;
    end
    if (div_wr && int'(div_sel) < STAGES) begin
      m_pdv[div_sel] = int'(div_data);
      m_pend[div_sel] = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit c, input int pd,
                     input bit w, input int s, input int dd);
    @(negedge clk);
    rst = r; en = e; clear = c; prescale_div = PW'(pd);
    div_wr = w; div_sel = SW'(s); div_data = DIV_W'(dd);
    if (rst) model_reset();
    else model_step();
    q.push_back(pack_exp());
  endtask

  task automatic run(input int n, input bit e, input int pd);
    for (int k = 0; k < n; k++) cyc(0, e, 0, pd, 0, 0, 0);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    en = 1; clear = 0; div_wr = 0;
    #2 rst = 1;
    #1;
    tests++;
    if ({pending, level, tick} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h required 0", {pending, level, tick});
    end
    model_reset();
    q.push_back(pack_exp());
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare against queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if ({pending, level, tick} !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got p/l/t %h required %h", $time, {pending, level, tick}, e);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int dd, r;
    rst = 1; en = 0; clear = 0; prescale_div = '0;
    div_wr = 0; div_sel = '0; div_data = '0;
    model_reset();

    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    run(3, 0, 1);
    // Default divide-by-4 cascade at prescale 1
    run(200, 1, 1);
    // prescale 0 behaves as 1
    cyc(0, 1, 1, 0, 0, 0, 0);
    run(100, 1, 0);
    // Live prescale shrink from 10 to 3 with pcnt at 7
    cyc(0, 1, 1, 10, 0, 0, 0);
    run(7, 1, 10);
    run(40, 1, 3);
    // Stage 1 divisor change mid-count
    cyc(0, 1, 1, 1, 0, 0, 0);
    run(40, 1, 1);
    cyc(0, 1, 0, 1, 1, 1, 3);
    run(100, 1, 1);
    // Pass-through on stage 2 committed by clear; out-of-range write ignored
    cyc(0, 1, 0, 1, 1, 2, 1);
    cyc(0, 1, 1, 1, 0, 0, 0);
    run(60, 1, 1);
    cyc(0, 1, 0, 1, 1, STAGES, 9);
    run(60, 1, 1);
    // Pause mid-count, then resume
    run(13, 1, 1);
    run(50, 0, 1);
    run(80, 1, 1);
    // Async reset during counting
    async_reset_check();
    cyc(0, 1, 0, 1, 0, 0, 0);
    run(150, 1, 1);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 9);
      dd = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 255 : $urandom_range(2, 5);
      cyc(0, $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 3), $urandom_range(0, 7) == 0,
          $urandom_range(0, 7), dd);
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
